port_token_buffer: RTL

//  Elastic input stage placed directly upstream of an ALU port synchroniser.

---
 rtl/pkg_alu.sv | 14 +
 rtl/token_fifo.sv | 58 +++++
 rtl/port_token_buffer.sv | 118 +++++++++++
 3 files changed

// File: rtl/pkg_alu.sv
// Shared ALU-port types: token word layout and push-side framing states.
package pkg_alu;

  localparam int WIDTH_DATA = 32;

  typedef struct packed {
    logic                  acq;
    logic                  rls;
    logic [WIDTH_DATA-1:0] data;
  } tok_word_t;

  typedef enum logic {iDLE, mSG} fsm_frame;

endpackage

// File: rtl/token_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers; head is read combinationally.
module token_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [PW-1:0]    o_count
);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_count = wr_ptr_q - rd_ptr_q;
  assign o_rdata = mem_q[rd_ptr_q[AW-1:0]];

  // Full/empty are judged on current state, so a push at full is refused even with a pop
  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop & ~o_empty;

  // Next-pointer computation; pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents are don't-care after reset
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/port_token_buffer.sv
// Elastic input stage ahead of the ALU port synchroniser: FIFO, link backpressure,
// framing tracking and sticky error flags.
module port_token_buffer
  import pkg_alu::*;
#(
  parameter int WIDTH_DATA = pkg_alu::WIDTH_DATA,
  parameter int DEPTH      = 4,
  parameter int SKID       = 2,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_Valid,
  input  logic                  I_Acq,
  input  logic                  I_Rls,
  input  logic [WIDTH_DATA-1:0] I_Data,
  input  logic                  I_Nack,
  output logic                  O_Valid,
  output logic                  O_Acq,
  output logic                  O_Rls,
  output logic [WIDTH_DATA-1:0] O_Data,
  output logic                  O_Nack,
  output logic [CW-1:0]         O_Count,
  output logic                  O_InMsg,
  output logic                  O_Overflow,
  output logic                  O_ProtoErr
);

  localparam logic [CW-1:0] NACK_TH = CW'(DEPTH - SKID);

  tok_word_t     wr_word, rd_word;
  logic          full, empty, push, pop;
  logic [CW-1:0] count, count_next;

  fsm_frame frame_q, frame_d;
  logic     nack_q, nack_d;
  logic     inmsg_q, inmsg_d;
  logic     ovf_q, ovf_d;
  logic     perr_q, perr_d;

  assign wr_word = '{acq: I_Acq, rls: I_Rls, data: I_Data};
  assign push    = I_Valid & ~full;
  assign pop     = ~empty & ~I_Nack;

  token_fifo #(
    .WIDTH (($bits(tok_word_t))),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (push),
    .i_wdata (wr_word),
    .i_pop   (pop),
    .o_rdata (rd_word),
    .o_full  (full),
    .o_empty (empty),
    .o_count (count)
  );

  assign O_Valid    = ~empty;
  assign O_Acq      = ~empty & rd_word.acq;
  assign O_Rls      = ~empty & rd_word.rls;
  assign O_Data     = empty ? '0 : rd_word.data;
  assign O_Count    = count;
  assign O_Nack     = nack_q;
  assign O_InMsg    = inmsg_q;
  assign O_Overflow = ovf_q;
  assign O_ProtoErr = perr_q;

  assign count_next = count + CW'(push) - CW'(pop);

  // Framing FSM, backpressure threshold, pop-side message flag and sticky errors
  always_comb begin
    frame_d = frame_q;
    nack_d  = (count_next >= NACK_TH);
    inmsg_d = inmsg_q;
    ovf_d   = ovf_q | (I_Valid & full);
    perr_d  = perr_q;

    if (push) begin
      unique case (frame_q)
        iDLE: begin
          // Acq+Rls together is a complete one-word message
          if (I_Rls && !I_Acq) perr_d  = 1'b1;
          if (I_Acq && !I_Rls) frame_d = mSG;
        end
        mSG: begin
          if (I_Acq) perr_d  = 1'b1;
          if (I_Rls) frame_d = iDLE;
        end
        default: frame_d = iDLE;
      endcase
    end

    if (pop) begin
      if (rd_word.rls)      inmsg_d = 1'b0;
      else if (rd_word.acq) inmsg_d = 1'b1;
    end
  end

  // Control state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_q <= iDLE;
      nack_q  <= 1'b0;
      inmsg_q <= 1'b0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      frame_q <= frame_d;
      nack_q  <= nack_d;
      inmsg_q <= inmsg_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
    end
  end

endmodule
